// File: rtl/pong_pkg.sv
// Constants and encodings shared between score_keeper and the game state machine.
package pong_pkg;

  localparam int unsigned PHASE_W = 2;
  localparam int unsigned DEF_SCORE_W = 3;
  localparam int unsigned DEF_WIN_SCORE = 5;

  localparam logic [PHASE_W-1:0] ST_SPLASH = 2'd0;
  localparam logic [PHASE_W-1:0] ST_MIDDLE = 2'd1;
  localparam logic [PHASE_W-1:0] ST_PLAY   = 2'd2;
  localparam logic [PHASE_W-1:0] ST_END    = 2'd3;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10
  } winner_t;

endpackage

// File: rtl/score_keeper_edge_rise.sv
// Registered rising-edge detector: rise_c is high while the level is high
// and was low at the previous clock edge.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise_c
);

  logic level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_q <= 1'b0;
    else     level_q <= level;
  end

  assign rise_c = level & ~level_q;

endmodule

// File: rtl/score_keeper.sv
// Turns goal levels into saturating per-player scores, a one-cycle score strobe,
// winner and next-server tracking, gated by the game phase.
module score_keeper
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE = DEF_WIN_SCORE,
  parameter int unsigned SCORE_W   = DEF_SCORE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         cur_state,
  input  logic               goal_p1,
  input  logic               goal_p2,
  output logic [SCORE_W-1:0] p1,
  output logic [SCORE_W-1:0] p2,
  output logic               score,
  output logic [1:0]         winner,
  output logic               serve
);

  localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

  typedef enum logic [1:0] {IDLE, ARMED, LOCKED} fsm_t;

  fsm_t state;
  logic ev_p1, ev_p2;
  logic pend_p1, pend_p2;
  logic cand_p1, cand_p2;
  logic [SCORE_W-1:0] p1_inc, p2_inc;

  edge_rise u_rise_p1 (.clk(clk), .rst(rst), .level(goal_p1), .rise_c(ev_p1));
  edge_rise u_rise_p2 (.clk(clk), .rst(rst), .level(goal_p2), .rise_c(ev_p2));

  // Award candidates combine a fresh edge with any point latched during middle
  always_comb begin
    cand_p1 = ev_p1 | pend_p1;
    cand_p2 = ev_p2 | pend_p2;
    p1_inc  = (p1 == WIN_VAL) ? p1 : p1 + SCORE_W'(1);
    p2_inc  = (p2 == WIN_VAL) ? p2 : p2 + SCORE_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      p1      <= '0;
      p2      <= '0;
      score   <= 1'b0;
      winner  <= WIN_NONE;
      serve   <= 1'b0;
      pend_p1 <= 1'b0;
      pend_p2 <= 1'b0;
    end else begin
      score <= 1'b0;
      case (cur_state)
        ST_SPLASH: begin
          state   <= IDLE;
          p1      <= '0;
          p2      <= '0;
          winner  <= WIN_NONE;
          serve   <= 1'b0;
          pend_p1 <= 1'b0;
          pend_p2 <= 1'b0;
        end
        ST_END: begin
          state   <= IDLE;
          pend_p1 <= 1'b0;
          pend_p2 <= 1'b0;
        end
        ST_MIDDLE: begin
          state <= ARMED;
          // A simultaneous pending pair is a let and cancels out
          if (state == ARMED) begin
            if (cand_p1 && cand_p2) begin
              pend_p1 <= 1'b0;
              pend_p2 <= 1'b0;
            end else begin
              pend_p1 <= cand_p1;
              pend_p2 <= cand_p2;
            end
          end
        end
        default: begin
          if (state == ARMED && winner == WIN_NONE) begin
            if (cand_p1 && !cand_p2) begin
              p1      <= p1_inc;
              score   <= 1'b1;
              serve   <= 1'b1;
              state   <= LOCKED;
              pend_p1 <= 1'b0;
              pend_p2 <= 1'b0;
              if (p1_inc == WIN_VAL) winner <= WIN_P1;
            end else if (cand_p2 && !cand_p1) begin
              p2      <= p2_inc;
              score   <= 1'b1;
              serve   <= 1'b0;
              state   <= LOCKED;
              pend_p1 <= 1'b0;
              pend_p2 <= 1'b0;
              if (p2_inc == WIN_VAL) winner <= WIN_P2;
            end else if (cand_p1 && cand_p2) begin
              pend_p1 <= 1'b0;
              pend_p2 <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Directed self-checking bench for score_keeper with hand-computed expectations.
module tb_score_keeper;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] cur_state;
  logic       goal_p1, goal_p2;
  logic [2:0] p1, p2;
  logic       score;
  logic [1:0] winner;
  logic       serve;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses;
  logic got_score;

  score_keeper #(.WIN_SCORE(5), .SCORE_W(3)) dut (
    .clk(clk), .rst(rst), .cur_state(cur_state),
    .goal_p1(goal_p1), .goal_p2(goal_p2),
    .p1(p1), .p2(p2), .score(score), .winner(winner), .serve(serve)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full middle/play round ending with a single goal_p1 pulse in play
  task automatic round_p1(output logic sc);
    cur_state = 2'd1; step(); step();
    cur_state = 2'd2; step();
    goal_p1 = 1'b1; step();
    sc = score;
    goal_p1 = 1'b0; step();
  endtask

  initial begin
    rst = 1'b1; cur_state = 2'd0; goal_p1 = 1'b0; goal_p2 = 1'b0;
    #3;
    check("rst_p1", 32'(p1), 0);
    check("rst_p2", 32'(p2), 0);
    check("rst_score", 32'(score), 0);
    check("rst_winner", 32'(winner), 0);
    check("rst_serve", 32'(serve), 0);
    step(); rst = 1'b0; step();

    // single p1 point
    cur_state = 2'd1; step(); step();
    cur_state = 2'd2; step();
    goal_p1 = 1'b1; step();
    check("t1_p1", 32'(p1), 1);
    check("t1_score_hi", 32'(score), 1);
    check("t1_serve", 32'(serve), 1);
    goal_p1 = 1'b0; step();
    check("t1_score_lo", 32'(score), 0);

    // goal_p2 held 10 cycles across middle->play
    cur_state = 2'd1; step(); step();
    pulses = 0;
    goal_p2 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) cur_state = 2'd2;
      step();
      if (score) pulses++;
    end
    goal_p2 = 1'b0;
    check("t2_pulses", 32'(pulses), 1);
    check("t2_p2", 32'(p2), 1);
    check("t2_serve", 32'(serve), 0);
    step();

    // both goals rise in the same play cycle: a let
    cur_state = 2'd1; step(); step();
    cur_state = 2'd2; step();
    goal_p1 = 1'b1; goal_p2 = 1'b1; step();
    check("t3_score", 32'(score), 0);
    check("t3_p1", 32'(p1), 1);
    check("t3_p2", 32'(p2), 1);
    goal_p1 = 1'b0; goal_p2 = 1'b0; step();
    goal_p2 = 1'b1; step();
    check("t3_still_armed", 32'(p2), 2);
    goal_p2 = 1'b0; step();

    // p1=3, p2=2, then splash clears everything
    round_p1(got_score);
    round_p1(got_score);
    check("t4_p1", 32'(p1), 3);
    check("t4_p2", 32'(p2), 2);
    cur_state = 2'd0; step();
    check("t4_spl_p1", 32'(p1), 0);
    check("t4_spl_p2", 32'(p2), 0);
    check("t4_spl_serve", 32'(serve), 0);
    check("t4_spl_winner", 32'(winner), 0);

    // pending pair latched in middle cancels out
    cur_state = 2'd1; step(); step();
    goal_p1 = 1'b1; goal_p2 = 1'b1; step();
    goal_p1 = 1'b0; goal_p2 = 1'b0; step();
    cur_state = 2'd2; step();
    check("let_mid_score", 32'(score), 0);
    check("let_mid_p1", 32'(p1), 0);
    cur_state = 2'd0; step();

    // five p1 points win; a sixth is ignored
    for (int r = 0; r < 5; r++) round_p1(got_score);
    check("t5_p1", 32'(p1), 5);
    check("t5_winner", 32'(winner), 1);
    round_p1(got_score);
    check("t5_6th_score", 32'(got_score), 0);
    check("t5_6th_p1", 32'(p1), 5);
    cur_state = 2'd3; step();
    goal_p1 = 1'b1; step(); goal_p1 = 1'b0; step();
    check("end_p1", 32'(p1), 5);
    check("end_winner", 32'(winner), 1);
    check("end_serve", 32'(serve), 1);

    // pending point from middle awarded on first play edge; LOCKED drops events
    cur_state = 2'd0; step();
    cur_state = 2'd1; step(); step();
    goal_p1 = 1'b1; step();
    goal_p1 = 1'b0; step();
    check("t6_mid_p1", 32'(p1), 0);
    cur_state = 2'd2; step();
    check("t6_pend_p1", 32'(p1), 1);
    check("t6_pend_score", 32'(score), 1);
    goal_p1 = 1'b1; step(); goal_p1 = 1'b0; step();
    check("t6_locked_p1", 32'(p1), 1);
    cur_state = 2'd1; step(); step();
    cur_state = 2'd2; step(); step();
    check("t6_not_latched", 32'(p1), 1);

    // async reset mid-round, no clock edge in between
    round_p1(got_score);
    check("t7_pre_p1", 32'(p1), 2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t7_rst_p1", 32'(p1), 0);
    check("t7_rst_serve", 32'(serve), 0);
    check("t7_rst_winner", 32'(winner), 0);
    step(); rst = 1'b0; step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
